// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS core.
// Resolves load-use stalls, taken-branch/jump flushes and external freeze
// into PC / IF-ID / ID-EX control, and keeps a registered record of the
// action plus wrapping event counters for performance readout.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ID_rs, ID_rt      register fields of the instruction in ID
//   ID_uses_rs/rt     ID instruction actually reads rs / rt
//   ID_j              ID instruction is a jump
//   EX_mem_read       load in EX (ID/EX register output)
//   EX_rt             load destination (ID/EX register output)
//   EX_branch_taken   beq/bne in EX resolved taken
//   freeze            external front-end hold
//   pc_write          PC load enable (combinational)
//   if_id_write       IF/ID load enable (combinational)
//   if_id_flush       clear IF/ID on next edge (combinational)
//   id_exe_bubble     zero ID/EX control on next edge (combinational)
//   hz_state          previous cycle's action: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
//   stall_cnt         load-use stall cycles (wrapping)
//   flush_cnt         branch/jump flush cycles (wrapping)
//   freeze_cnt        freeze cycles (wrapping)
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_j,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rt,
  input  logic             EX_branch_taken,
  input  logic             freeze,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_FREEZE = 2'd3
  } hz_e;

  hz_e              hz_state_d, hz_state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;

  logic rs_hit;
  logic rt_hit;
  logic lu;

  // A load targeting $0 never creates a dependency.
  always_comb begin
    rs_hit = ID_uses_rs && (ID_rs == EX_rt);
    rt_hit = ID_uses_rt && (ID_rt == EX_rt);
    lu     = EX_mem_read && (EX_rt != 5'd0) && (rs_hit || rt_hit);
  end

  // Priority: freeze > branch > load-use > jump > run.
  // Branch and jump flush share the FLUSH encoding; only the bubble differs,
  // since a taken branch must also kill the wrong-path instruction in ID.
  always_comb begin
    hz_state_d    = HZ_RUN;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    if (rst) begin
      hz_state_d = HZ_RUN;
    end else if (freeze) begin
      hz_state_d    = HZ_FREEZE;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
    end else if (EX_branch_taken) begin
      hz_state_d    = HZ_FLUSH;
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
    end else if (lu) begin
      hz_state_d    = HZ_STALL;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else if (ID_j) begin
      hz_state_d    = HZ_FLUSH;
      if_id_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_state_q   <= HZ_RUN;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      hz_state_q <= hz_state_d;
      unique case (hz_state_d)
        HZ_STALL:  stall_cnt_q  <= stall_cnt_q + 1'b1;
        HZ_FLUSH:  flush_cnt_q  <= flush_cnt_q + 1'b1;
        HZ_FREEZE: freeze_cnt_q <= freeze_cnt_q + 1'b1;
        default:   ;
      endcase
    end
  end

  assign hz_state   = hz_state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs, ID_rt, EX_rt;
  logic             ID_uses_rs, ID_uses_rt, ID_j;
  logic             EX_mem_read, EX_branch_taken, freeze;
  logic             pc_write, if_id_write, if_id_flush, id_exe_bubble;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int unsigned m_hz = 0, m_stall = 0, m_flush = 0, m_freeze = 0;
  int          last_act = 0;
  logic [1:0]  prev_hz = 2'd0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_j(ID_j),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt),
    .EX_branch_taken(EX_branch_taken), .freeze(freeze),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .hz_state(hz_state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, check combinational controls, then the
  // registered state after the edge. Actions: 0 run, 1 stall, 2 branch
  // flush, 3 freeze, 4 jump flush.
  task automatic run_cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic j,
                           input logic mr, input logic [4:0] ert,
                           input logic bt, input logic fz);
    int a;
    bit lu;
    @(negedge clk);
    rst = r; ID_rs = rs; ID_rt = rt; ID_uses_rs = urs; ID_uses_rt = urt;
    ID_j = j; EX_mem_read = mr; EX_rt = ert; EX_branch_taken = bt; freeze = fz;
    #1;
    lu = mr && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));
    if (r)       a = 0;
    else if (fz) a = 3;
    else if (bt) a = 2;
    else if (lu) a = 1;
    else if (j)  a = 4;
    else         a = 0;
    check("pc_write",      32'(pc_write),      32'(!(a == 1 || a == 3)));
    check("if_id_write",   32'(if_id_write),   32'(!(a == 1 || a == 3)));
    check("if_id_flush",   32'(if_id_flush),   32'(a == 2 || a == 4));
    check("id_exe_bubble", 32'(id_exe_bubble), 32'(a == 1 || a == 2));
    @(posedge clk);
    #1;
    if (r) begin
      m_hz = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      m_hz = (a == 4) ? 2 : a;
      if (a == 1) m_stall++;
      if (a == 2 || a == 4) m_flush++;
      if (a == 3) m_freeze++;
    end
    check("hz_state",   32'(hz_state),   m_hz);
    check("stall_cnt",  32'(stall_cnt),  m_stall % CMOD);
    check("flush_cnt",  32'(flush_cnt),  m_flush % CMOD);
    check("freeze_cnt", 32'(freeze_cnt), m_freeze % CMOD);
    if (r) prev_hz = 2'd0;
    else begin
      check("stall_b2b", 32'(prev_hz == 2'd1 && hz_state == 2'd1), 32'd0);
      prev_hz = hz_state;
    end
    last_act = r ? 0 : a;
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    run_cycle(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; ID_rs = '0; ID_rt = '0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    ID_j = 1'b0; EX_mem_read = 1'b0; EX_rt = '0; EX_branch_taken = 1'b0; freeze = 1'b0;

    // reset with random inputs
    do_reset();
    check("rst_hz", 32'(hz_state), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd1);

    // load-use stall, then bubble clears EX_mem_read
    run_cycle(0, 5'd5, 5'd9, 1, 0, 0, 1, 5'd5, 0, 0);
    check("lu_hz", 32'(hz_state), 32'd1);
    run_cycle(0, 5'd5, 5'd9, 1, 0, 0, 0, 5'd5, 0, 0);
    check("lu_hz_after", 32'(hz_state), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // load to $0 never stalls
    do_reset();
    run_cycle(0, 5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 0);
    check("r0_stall_cnt", 32'(stall_cnt), 32'd0);

    // branch beats load-use
    do_reset();
    run_cycle(0, 5'd7, 5'd3, 1, 1, 0, 1, 5'd7, 1, 0);
    check("br_hz", 32'(hz_state), 32'd2);
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // jump versus stall
    do_reset();
    run_cycle(0, 5'd4, 5'd2, 0, 1, 1, 1, 5'd2, 0, 0);
    run_cycle(0, 5'd4, 5'd2, 0, 1, 1, 0, 5'd2, 0, 0);
    check("j_stall_cnt", 32'(stall_cnt), 32'd1);
    check("j_flush_cnt", 32'(flush_cnt), 32'd1);

    // freeze 17 cycles over a pending load-use, counter wraps
    do_reset();
    for (int i = 0; i < 17; i++) run_cycle(0, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 1);
    check("frz_cnt_wrap", 32'(freeze_cnt), 32'd1);
    run_cycle(0, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0);
    check("frz_then_stall", 32'(hz_state), 32'd1);

    // randomized traffic; a stalled load is bubbled out of EX next cycle
    for (int i = 0; i < 3000; i++) begin
      logic r, mr;
      r  = ($urandom_range(0, 99) < 1);
      mr = ($urandom_range(0, 99) < 50);
      if (last_act == 1) mr = 1'b0;
      run_cycle(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 15),
                mr, 5'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It consumes the decode-stage register fields and the EX-side outputs of the ID/EX pipeline register, and drives the control inputs of the pipeline registers and the PC. These inputs are: PC write enable, IF/ID write enable, IF/ID flush, and ID/EX bubble insertion. It handles load-use stalls, taken-branch and jump flushes, and external freeze. It keeps a registered hazard state and wrapping event counters for the testbench and for performance readout.

## Interface
Parameters:
- CNT_W, 32, width of the stall, flush and freeze event counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_uses_rs  input  1  the instruction in ID reads rs.
- ID_uses_rt  input  1  the instruction in ID reads rt.
- ID_j  input  1  the instruction in ID is a jump.
- EX_mem_read  input  1  mem_read output of the ID/EX register (load in EX).
- EX_rt  input  5  rt output of the ID/EX register (load destination).
- EX_branch_taken  input  1  a beq/bne in EX is resolved taken.
- freeze  input  1  external hold (memory not ready); freezes the whole front end.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  clear IF/ID to nop on the next edge.
- id_exe_bubble  output  1  force the ID/EX control inputs to zero (nop) on the next edge.
- hz_state  output  2  registered action of the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
- stall_cnt  output  CNT_W  number of load-use stall cycles.
- flush_cnt  output  CNT_W  number of flush cycles (branch or jump).
- freeze_cnt  output  CNT_W  number of freeze cycles.

## Operation
- The load-use condition lu is EX_mem_read & (EX_rt != 0) & ((ID_uses_rs & ID_rs == EX_rt) | (ID_uses_rt & ID_rt == EX_rt)).
- Action priority, highest first: freeze > EX_branch_taken > lu > ID_j > run.
- FREEZE: pc_write=0, if_id_write=0, if_id_flush=0, id_exe_bubble=0. Every pipeline register holds; the downstream registers are gated by the same freeze.
- FLUSH (branch): pc_write=1 (branch target loaded), if_id_write=1, if_id_flush=1, id_exe_bubble=1. Both wrong-path instructions are killed.
- STALL (load-use): pc_write=0, if_id_write=0, if_id_flush=0, id_exe_bubble=1.
- FLUSH (jump): pc_write=1, if_id_write=1, if_id_flush=1, id_exe_bubble=0.
- RUN: pc_write=1, if_id_write=1, if_id_flush=0, id_exe_bubble=0.
- hz_state registers the encoding of the action selected this cycle. A branch flush and a jump flush both encode as FLUSH.
- Counters:
  - stall_cnt increments by 1 in every STALL cycle.
  - flush_cnt increments by 1 in every FLUSH cycle.
  - freeze_cnt increments by 1 in every FREEZE cycle.
  - Counters wrap modulo 2^CNT_W; no saturation.
- A stall is never issued in two consecutive cycles for the same load. After the bubble, EX_mem_read=0, so lu falls naturally. The bench asserts that STALL never follows STALL unless FREEZE intervenes.
- A load to $0 never stalls.

## Timing
- All control outputs are combinational from the current inputs. Zero-cycle latency is required so they act on the next clock edge.
- hz_state and the counters are registered and update one edge after the causing cycle.
- Reset, taken on a clk edge with rst=1:
  - hz_state=RUN and all counters are 0.
  - While rst=1, the control outputs are forced to the RUN values (pc_write=1, if_id_write=1, flush=0, bubble=0); the pipeline registers are themselves in reset.
  - Reset asserted mid-stall or mid-freeze takes effect on that edge; no pending action survives it.
- Simultaneous events:
  - branch_taken with lu gives FLUSH; the load-dependent instruction in ID is on the wrong path.
  - lu with ID_j gives STALL; the jump is retried next cycle.
  - freeze with anything gives FREEZE; the condition is re-evaluated after freeze drops.

## Test plan
- Reset check: assert rst for 2 cycles with random inputs -> after the edge, hz_state=0, all counters 0, pc_write=1, if_id_write=1, if_id_flush=0, id_exe_bubble=0.
- Load-use stall: EX_mem_read=1, EX_rt=5, ID_rs=5, ID_uses_rs=1 for one cycle; in the next cycle EX_mem_read=0 -> stall cycle gives pc_write=0, if_id_write=0, id_exe_bubble=1; then RUN; hz_state reads 1 then 0; stall_cnt=1.
- Load to $0: EX_rt=0, ID_rs=0, EX_mem_read=1 -> RUN values, stall_cnt stays 0.
- Branch beats load-use: EX_branch_taken=1 and lu=1 in the same cycle -> if_id_flush=1, id_exe_bubble=1, pc_write=1; hz_state=2; flush_cnt=1, stall_cnt=0.
- Jump versus stall: ID_j=1 and lu=1 -> STALL. Next cycle ID_j=1, lu=0 -> if_id_flush=1, id_exe_bubble=0; stall_cnt=1, flush_cnt=1.
- Freeze and wrap: with CNT_W=4, hold freeze=1 for 17 cycles while lu=1 -> all enables 0 and bubble 0 throughout; freeze_cnt=1 (wrapped); after freeze drops, the stall is taken.
